// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid/payload pipeline registers with per-stage stall and
// flush, automatic bubble insertion behind a stall, and a saturating bubble counter.

module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             kill_i,
    input  logic             hold_i,
    input  logic             up_hold_i,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Kill beats hold; a held upstream neighbour leaves us a bubble, not a copy.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (kill_i) begin
            vld_d = 1'b0;
        end else if (!hold_i) begin
            if (up_hold_i) begin
                vld_d = 1'b0;
            end else begin
                vld_d  = up_vld_i;
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

module pipe_stage_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [WIDTH-1:0]  data_i,
    output logic              ready_o,
    input  logic [STAGES-1:0] stall_i,
    input  logic [STAGES-1:0] flush_i,
    input  logic              cnt_clr_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  data_o,
    output logic [STAGES-1:0] stage_valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    logic [STAGES-1:0]            hold, kill, bub;
    logic [STAGES-1:0]            stg_vld, up_vld, up_hold;
    logic [STAGES-1:0][WIDTH-1:0] stg_data, up_data;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    // Stage 0 is fed from the input port; every older stage from its younger neighbour.
    assign up_vld  = {stg_vld[STAGES-2:0], valid_i};
    assign up_data = {stg_data[STAGES-2:0], data_i};
    assign up_hold = {hold[STAGES-2:0], 1'b0};
    assign bub[0]  = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        assign hold[k] = |stall_i[STAGES-1:k];
        assign kill[k] = |flush_i[STAGES-1:k];
        if (k > 0) begin : g_bub
            assign bub[k] = hold[k-1] & ~hold[k] & ~kill[k];
        end

        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .kill_i    (kill[k]),
            .hold_i    (hold[k]),
            .up_hold_i (up_hold[k]),
            .up_vld_i  (up_vld[k]),
            .up_data_i (up_data[k]),
            .vld_o     (stg_vld[k]),
            .data_o    (stg_data[k])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
            cnt_d = '0;
        else if (|bub && !(&cnt_q))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign ready_o       = ~hold[0];
    assign valid_o       = stg_vld[STAGES-1];
    assign data_o        = stg_data[STAGES-1];
    assign stage_valid_o = stg_vld;
    assign bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Randomised and directed bench for pipe_stage_chain against an array-based
// reference model of the stage rules.

module tb_pipe_stage_chain;
    localparam int W = 32;
    localparam int S = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, valid_i, ready_o, cnt_clr, valid_o;
    logic [W-1:0]  data_i, data_o;
    logic [S-1:0]  stall, flush, stage_valid;
    logic [CW-1:0] bcnt;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
        .stall_i(stall), .flush_i(flush), .cnt_clr_i(cnt_clr), .valid_o(valid_o),
        .data_o(data_o), .stage_valid_o(stage_valid), .bubble_cnt_o(bcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [S-1:0] m_vld;
    logic [W-1:0] m_data [S];
    int           m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_set(input logic [S-1:0] v, input int from);
        for (int j = from; j < S; j++) if (v[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                              input logic [S-1:0] fl, input logic clr, input logic rs);
        logic [S-1:0] nv;
        logic [W-1:0] nd [S];
        bit           ev;
        ev = 1'b0;
        for (int k = 0; k < S; k++) begin
            nv[k] = m_vld[k];
            nd[k] = m_data[k];
            if (rs) begin
                nv[k] = 1'b0; nd[k] = '0;
            end else if (any_set(fl, k)) begin
                nv[k] = 1'b0;
            end else if (any_set(st, k)) begin
                // stage frozen
            end else if (k == 0) begin
                nv[k] = v; nd[k] = d;
            end else if (any_set(st, k-1)) begin
                nv[k] = 1'b0;
                ev = 1'b1;
            end else begin
                nv[k] = m_vld[k-1]; nd[k] = m_data[k-1];
            end
        end
        m_vld = nv;
        for (int k = 0; k < S; k++) m_data[k] = nd[k];
        if (rs || clr) m_cnt = 0;
        else if (ev && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    // One clock: drive inputs, check ready_o, clock, check registered outputs.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [S-1:0] st,
                        input logic [S-1:0] fl, input logic clr, input logic rs);
        valid_i = v; data_i = d; stall = st; flush = fl; cnt_clr = clr; rst = rs;
        #1;
        chk("ready_o", ready_o, st == '0);
        @(posedge clk);
        model_edge(v, d, st, fl, clr, rs);
        #1;
        chk("stage_valid_o", stage_valid, m_vld);
        chk("valid_o", valid_o, m_vld[S-1]);
        if (m_vld[S-1]) chk("data_o", data_o, m_data[S-1]);
        chk("bubble_cnt_o", bcnt, m_cnt);
    endtask

    initial begin
        int lat;
        logic [S-1:0] st, fl;
        m_vld = '0; m_cnt = 0;
        for (int k = 0; k < S; k++) m_data[k] = '0;
        valid_i = 0; data_i = '0; stall = '0; flush = '0; cnt_clr = 0; rst = 1;

        // Reset, with ready_o following stall_i during reset
        valid_i = 1; stall = 4'b0001;
        #1;
        chk("ready_in_reset", ready_o, 1'b0);
        @(posedge clk);
        model_edge(1'b1, '0, 4'b0001, '0, 1'b0, 1'b1);
        #1;
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_stage_valid", stage_valid, 4'h0);
        chk("rst_bcnt", bcnt, 4'h0);

        // Streaming and latency
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h10 + i, '0, '0, 1'b0, 1'b0);
            if (lat == 0 && valid_o) lat = i + 1;
        end
        chk("latency", lat, S);
        chk("stream_bcnt", bcnt, 4'h0);

        // Stall stage 1 for two cycles
        step(1'b1, 32'h20, 4'b0010, '0, 1'b0, 1'b0);
        step(1'b1, 32'h21, 4'b0010, '0, 1'b0, 1'b0);
        chk("stall_bcnt", bcnt, 4'h2);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h22 + i, '0, '0, 1'b0, 1'b0);

        // Flush: fill A0..A3 then flush stage 1
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, '0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hA4, 4'b0000, 4'b0010, 1'b0, 1'b0);
        chk("flush_sv", stage_valid[1:0], 2'b00);
        chk("flush_d3", data_o, 32'hA1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("flush_next", data_o, 32'hA2);

        // Stall + flush on stage 2
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + i, '0, '0, 1'b1, 1'b0);
        step(1'b1, 32'hB4, 4'b0100, 4'b0100, 1'b0, 1'b0);
        chk("sf_sv", stage_valid, 4'b0000);
        chk("sf_bcnt", bcnt, 4'h1);

        // Saturation, then clear together with a bubble event
        for (int i = 0; i < 20; i++) step(1'b1, 32'hC0 + i, 4'b0001, '0, 1'b0, 1'b0);
        chk("sat_bcnt", bcnt, 4'hF);
        step(1'b1, 32'hD0, 4'b0001, '0, 1'b1, 1'b0);
        chk("clr_bcnt", bcnt, 4'h0);

        // Reset mid-stream with everything stalled
        for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + i, '0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("mrst_sv", stage_valid, 4'h0);
        chk("mrst_data", data_o, 32'h0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'hF0 + i, '0, '0, 1'b0, 1'b0);
            if (lat == 0 && valid_o) lat = i + 1;
        end
        chk("mrst_latency", lat, S);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < S; k++) begin
                st[k] = ($urandom_range(0, 7) == 0);
                fl[k] = ($urandom_range(0, 15) == 0);
            end
            step($urandom_range(0, 3) != 0, $urandom, st, fl,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of pipeline registers generalising the fixed per-boundary IF/ID and ID/EX registers of the CPU into one block of STAGES stages. Each stage carries a WIDTH-bit payload plus a valid bit, and has its own stall and flush inputs from the hazard unit. Stalls propagate to younger stages with automatic bubble insertion; flushes squash a stage and everything younger. A saturating counter reports stall-inserted bubbles for performance measurement.

## Interface
- WIDTH, 32, payload bits per stage
- STAGES, 4, number of register stages; legal range 2..16
- CNT_W, 16, bubble counter width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input item present
- data_i  in  WIDTH  input payload
- ready_o  out  1  stage 0 can capture this cycle (combinational)
- stall_i  in  STAGES  bit k: hold stage k (and all younger)
- flush_i  in  STAGES  bit k: squash stage k (and all younger)
- cnt_clr_i  in  1  synchronous clear of bubble counter
- valid_o  out  1  valid of stage STAGES-1
- data_o  out  WIDTH  payload of stage STAGES-1
- stage_valid_o  out  STAGES  valid bit of every stage, for the hazard unit
- bubble_cnt_o  out  CNT_W  stall-inserted bubble count

## Operation
- Stage 0 is youngest (fed by data_i), stage STAGES-1 is oldest (drives outputs). Only one clock and one reset: clk_i, synchronous active-high rst_i.
- hold[k] = OR of stall_i[j] for j >= k. kill[k] = OR of flush_i[j] for j >= k.
- Next state of stage k, in priority order:
  - rst_i: valid=0, data=0.
  - kill[k]: valid=0; data unchanged.
  - hold[k]: valid and data unchanged.
  - k=0: valid=valid_i, data=data_i.
  - k>0, hold[k-1]: valid=0 (bubble); data unchanged.
  - else: valid and data copied from stage k-1's current contents.
- ready_o = ~hold[0]. The input is accepted when valid_i & ready_o. If kill[0] is set in that cycle, the accepted item is discarded; upstream does not retry.
- Flush acts on the captured value of stage k only. Stage k+1 still loads stage k's current contents when it is not itself killed or held.
- Bubble event: for some k >= 1, hold[k-1] & ~hold[k] & ~kill[k]. At most one such k exists per cycle. bubble_cnt_o increments by 1 on each event.
  - The counter saturates at 2^CNT_W-1.
  - cnt_clr_i forces 0. It takes priority over increment and is overridden by nothing except rst_i, which also forces 0.
- There is no downstream backpressure other than stall_i[STAGES-1]. While it is asserted, valid_o and data_o repeat.
- Invalid stages still shift their data. The payload of an invalid stage is don't-care except after reset, when it is 0.

## Timing
- Reset values: valid_o=0, data_o=0, stage_valid_o=0, bubble_cnt_o=0. ready_o follows stall_i combinationally during reset.
- Latency: an item accepted at edge N appears on valid_o/data_o after edge N+STAGES-1, i.e. STAGES edges including capture, with no stalls.
- Throughput: one item per cycle with no stalls or flushes.
- Stall asserted for C cycles at stage k adds exactly C cycles to the latency of items in stages <= k. It inserts C bubbles at stage k+1 and adds C to the counter.
- Simultaneous stall_i[k] and flush_i[k]: the stage is squashed (valid=0) and stages < k are squashed. Stage k+1 receives a bubble and the counter increments unless kill[k+1].
- Reset asserted mid-operation clears every stage on that edge regardless of stall_i/flush_i. Input offered in the reset cycle is lost.
- Outputs are registered except ready_o.

## Test plan
- Streaming: STAGES=4, WIDTH=32; feed 0x10,0x11,0x12,… every cycle with stall_i=0, flush_i=0 → valid_o rises 4 edges after the first accept; data_o sequence is 0x10,0x11,… back-to-back; bubble_cnt_o=0.
- Stall: stream with stall_i=4'b0010 for 2 cycles → stage 0/1 hold; ready_o=0 for 2 cycles; stage 2 gets 2 bubbles; valid_o shows 2 low cycles; bubble_cnt_o=2; no item lost or duplicated.
- Flush: stages hold 0xA0..0xA3 (stage 0=0xA3); pulse flush_i=4'b0010 → next cycle stage_valid_o[1:0]=0; stage 2 holds 0xA2, stage 3 holds 0xA1; 0xA3 and the input item never reach data_o.
- Stall+flush same stage: stall_i=flush_i=4'b0100 for 1 cycle → stages 0..2 invalid; stage 3 receives a bubble; bubble_cnt_o increments by 1.
- Counter: CNT_W=4, hold stall_i[0] for 20 cycles → bubble_cnt_o saturates at 15. Pulse cnt_clr_i together with a bubble event → 0.
- Reset mid-stream: assert rst_i for 1 cycle with all stages valid and stall_i=4'b1111 → all outputs 0 on the next edge; streaming resumes with normal latency.
